// File: rtl/bayer_frame_ctrl.sv
// Frame sequencer in front of the bayer2rgb core: pads/trims lines to IMAGE_WIDTH, counts frames,
// and waits out the core pipeline. Define BAYER_CTRL_CONT_EN for continuous (auto re-arm) mode.
module bayer_frame_ctrl #(
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 466,
   parameter int PIPE_LAT     = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [1:0]  cfg_pattern,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_sof,
   input  logic        s_eol,
   output logic        s_ready,
   output logic        core_valid,
   output logic [7:0]  core_data,
   output logic [1:0]  core_pattern,
   output logic        busy,
   output logic        frame_done,
   output logic        err_line,
   output logic        err_sof,
   output logic [15:0] frame_cnt
);

   localparam int XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
   localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_SOF, S_ACTIVE, S_PAD, S_SKIP, S_DRAIN
   } state_t;

   state_t        state, state_nxt, beat_nxt, done_nxt;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [DW-1:0] drain_cnt;
   logic          accept, fwd, issue, x_last, y_last, drain_end, start_ok, relatch;

   // The sof beat that opens a frame is handled exactly like an ACTIVE beat at x=0.
   assign accept    = s_valid & s_ready;
   assign fwd       = accept & ((state == S_ACTIVE) | ((state == S_WAIT_SOF) & s_sof));
   assign issue     = fwd | (state == S_PAD);
   assign x_last    = (x == X_LAST);
   assign y_last    = (y == Y_LAST);
   assign drain_end = (state == S_DRAIN) && (drain_cnt == D_LAST);
   assign start_ok  = start & ~abort & (state == S_IDLE);

`ifdef BAYER_CTRL_CONT_EN
   assign done_nxt = S_WAIT_SOF;
   assign relatch  = start_ok | drain_end;
`else
   assign done_nxt = S_IDLE;
   assign relatch  = start_ok;
`endif

   // Where an accepted, forwarded beat sends the FSM.
   always_comb begin
      if (x_last)
         beat_nxt = y_last ? S_DRAIN : (s_eol ? S_ACTIVE : S_SKIP);
      else
         beat_nxt = s_eol ? S_PAD : S_ACTIVE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:     if (start) state_nxt = S_WAIT_SOF;
         S_WAIT_SOF: if (fwd) state_nxt = beat_nxt;
         S_ACTIVE:   if (fwd) state_nxt = beat_nxt;
         S_PAD:      if (x_last) state_nxt = y_last ? S_DRAIN : S_ACTIVE;
         S_SKIP:     if (accept & s_eol) state_nxt = S_ACTIVE;
         S_DRAIN:    if (drain_end) state_nxt = done_nxt;
         default:    state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   always_comb begin
      s_ready = (state == S_WAIT_SOF) || (state == S_ACTIVE) || (state == S_SKIP);
      busy    = (state != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x            <= '0;
         y            <= '0;
         drain_cnt    <= '0;
         core_valid   <= 1'b0;
         core_data    <= '0;
         core_pattern <= '0;
         frame_done   <= 1'b0;
         err_line     <= 1'b0;
         err_sof      <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;
         core_valid <= 1'b0;
         if (abort) begin
            x         <= '0;
            y         <= '0;
            drain_cnt <= '0;
         end else begin
            core_valid <= issue;
            if (fwd) core_data <= s_data;
            if (issue) begin
               if (x_last) begin
                  x <= '0;
                  y <= y_last ? '0 : y + 1'b1;
               end else begin
                  x <= x + 1'b1;
               end
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (drain_end) begin
               frame_done <= 1'b1;
               frame_cnt  <= frame_cnt + 1'b1;
            end
            if (relatch) core_pattern <= cfg_pattern;
            if (start_ok) begin
               err_line <= 1'b0;
               err_sof  <= 1'b0;
            end
            if (fwd && (s_eol != x_last)) err_line <= 1'b1;
            if (accept && (state == S_ACTIVE) && s_sof) err_sof <= 1'b1;
         end
      end
   end

endmodule
